// File: rtl/branch_resolve_scoreboard.sv
// branch_resolve_scoreboard: in-order queue of branch predictions, resolved against actual outcomes
// to produce registered predictor training updates and saturating accuracy counters.
module branch_resolve_scoreboard #(
  parameter int IP_W  = 64,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic [IP_W-1:0]            pred_ip,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic                       flush,
  input  logic                       clr_cnt,
  output logic                       upd_valid,
  output logic [IP_W-1:0]            upd_ip,
  output logic                       upd_taken,
  output logic                       upd_mispredict,
  output logic [CNT_W-1:0]           inst_cnt,
  output logic [CNT_W-1:0]           mispred_cnt,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       full,
  output logic                       empty,
  output logic                       underflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [IP_W:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d, upd_mis_q, upd_mis_d;
  logic [IP_W-1:0]   upd_ip_q, upd_ip_d;
  logic [CNT_W-1:0]  inst_q, inst_d, mis_q, mis_d, inst_b, mis_b;
  logic              uflow_q, uflow_d;
  logic              push, pop, mis_hit;
  logic [IP_W:0]     head;
  assign full       = occ_q == OW'(DEPTH);
  assign empty      = occ_q == '0;
  assign pred_ready = !full;
  assign push       = pred_valid && !full && !flush;
  assign pop        = res_valid && !empty && !flush;
  assign head       = mem_q[rd_q];
  assign mis_hit    = head[0] ^ res_taken;
  always_comb begin
    occ_d       = flush ? '0 : occ_q + OW'(push) - OW'(pop);
    wr_d        = flush ? '0 : wr_q + AW'(push);
    rd_d        = flush ? '0 : rd_q + AW'(pop);
    upd_valid_d = pop;
    upd_ip_d    = pop ? head[IP_W:1] : upd_ip_q;
    upd_taken_d = pop ? res_taken : upd_taken_q;
    upd_mis_d   = pop ? mis_hit : upd_mis_q;
    inst_b      = clr_cnt ? '0 : inst_q;
    mis_b       = clr_cnt ? '0 : mis_q;
    // a pop coinciding with clr_cnt still counts on top of the cleared value
    inst_d      = inst_b + CNT_W'(pop && !(&inst_b));
    mis_d       = mis_b + CNT_W'(pop && mis_hit && !(&mis_b));
    uflow_d     = uflow_q | (res_valid && empty && !flush);
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {pred_ip, pred_taken};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q        <= '0;
      rd_q        <= '0;
      occ_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_ip_q    <= '0;
      upd_taken_q <= 1'b0;
      upd_mis_q   <= 1'b0;
      inst_q      <= '0;
      mis_q       <= '0;
      uflow_q     <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      occ_q       <= occ_d;
      upd_valid_q <= upd_valid_d;
      upd_ip_q    <= upd_ip_d;
      upd_taken_q <= upd_taken_d;
      upd_mis_q   <= upd_mis_d;
      inst_q      <= inst_d;
      mis_q       <= mis_d;
      uflow_q     <= uflow_d;
    end
  assign upd_valid      = upd_valid_q;
  assign upd_ip         = upd_ip_q;
  assign upd_taken      = upd_taken_q;
  assign upd_mispredict = upd_mis_q;
  assign inst_cnt       = inst_q;
  assign mispred_cnt    = mis_q;
  assign occupancy      = occ_q;
  assign underflow_err  = uflow_q;
endmodule

// File: tb/tb_branch_resolve_scoreboard.sv
// tb_branch_resolve_scoreboard: directed scenarios for branch_resolve_scoreboard (DEPTH 8, CNT_W 4).
module tb_branch_resolve_scoreboard;
  logic        clk = 0, reset = 0;
  logic        pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0, flush = 0, clr_cnt = 0;
  logic [63:0] pred_ip = '0;
  logic        pred_ready, upd_valid, upd_taken, upd_mispredict, full, empty, underflow_err;
  logic [63:0] upd_ip;
  logic [3:0]  inst_cnt, mispred_cnt, occupancy;
  int n_cmp = 0, n_bad = 0;

  branch_resolve_scoreboard #(.IP_W(64), .DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_ip(pred_ip), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .clr_cnt(clr_cnt), .upd_valid(upd_valid), .upd_ip(upd_ip), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .inst_cnt(inst_cnt), .mispred_cnt(mispred_cnt),
    .occupancy(occupancy), .full(full), .empty(empty), .underflow_err(underflow_err));

  always #5 clk = ~clk;

  task automatic do_reset;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic cyc(input logic pv, input logic [63:0] ip, input logic pt, input logic rv,
                     input logic rt, input logic fl, input logic cl);
    pred_valid = pv; pred_ip = ip; pred_taken = pt; res_valid = rv; res_taken = rt;
    flush = fl; clr_cnt = cl;
    @(posedge clk); #1;
    pred_valid = 0; res_valid = 0; flush = 0; clr_cnt = 0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if (occupancy !== 4'd0) begin n_bad++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_cmp++; if ({empty, full, pred_ready} !== 3'b101) begin n_bad++; $display("FAIL reset_flags got %b want 101", {empty, full, pred_ready}); end
    n_cmp++; if ({upd_valid, upd_taken, upd_mispredict, underflow_err} !== 4'b0) begin n_bad++; $display("FAIL reset_upd got %b want 0000", {upd_valid, upd_taken, upd_mispredict, underflow_err}); end
    n_cmp++; if ({inst_cnt, mispred_cnt} !== 8'h00 || upd_ip !== 64'h0) begin n_bad++; $display("FAIL reset_cnt got %0d/%0d ip %h want 0/0 0", inst_cnt, mispred_cnt, upd_ip); end
  endtask

  task automatic test_basic;
    do_reset;
    cyc(1, 64'h100, 1, 0, 0, 0, 0);
    cyc(1, 64'h104, 0, 0, 0, 0, 0);
    n_cmp++; if (occupancy !== 4'd2 || upd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_push got occ %0d uv %b want 2 0", occupancy, upd_valid); end
    cyc(0, 0, 0, 1, 1, 0, 0);
    n_cmp++; if ({upd_valid, upd_taken, upd_mispredict} !== 3'b110 || upd_ip !== 64'h100) begin n_bad++; $display("FAIL basic_upd0 got %b ip %h want 110 100", {upd_valid, upd_taken, upd_mispredict}, upd_ip); end
    cyc(0, 0, 0, 1, 1, 0, 0);
    n_cmp++; if ({upd_valid, upd_taken, upd_mispredict} !== 3'b111 || upd_ip !== 64'h104) begin n_bad++; $display("FAIL basic_upd1 got %b ip %h want 111 104", {upd_valid, upd_taken, upd_mispredict}, upd_ip); end
    n_cmp++; if (inst_cnt !== 4'd2 || mispred_cnt !== 4'd1) begin n_bad++; $display("FAIL basic_cnt got %0d/%0d want 2/1", inst_cnt, mispred_cnt); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (upd_valid !== 1'b0 || upd_ip !== 64'h104 || upd_mispredict !== 1'b1 || empty !== 1'b1) begin n_bad++; $display("FAIL basic_hold got uv %b ip %h mis %b empty %b want 0 104 1 1", upd_valid, upd_ip, upd_mispredict, empty); end
  endtask

  task automatic test_full;
    logic [63:0] exp_ip;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 64'h50 + 64'(i), 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
    end
    for (int i = 0; i < 8; i++) cyc(1, 64'h200 + 64'(4 * i), 1'(i % 2), 0, 0, 0, 0);
    n_cmp++; if ({full, pred_ready, empty} !== 3'b100 || occupancy !== 4'd8) begin n_bad++; $display("FAIL full_flags got %b occ %0d want 100 8", {full, pred_ready, empty}, occupancy); end
    cyc(1, 64'hBAD, 1, 0, 0, 0, 0);
    n_cmp++; if (occupancy !== 4'd8) begin n_bad++; $display("FAIL full_drop got %0d want 8", occupancy); end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      exp_ip = 64'h200 + 64'(4 * i);
      n_cmp++; if (upd_valid !== 1'b1 || upd_ip !== exp_ip || upd_mispredict !== 1'(i % 2) || upd_taken !== 1'b0) begin n_bad++; $display("FAIL full_order%0d got uv %b ip %h mis %b want 1 %h %0d", i, upd_valid, upd_ip, upd_mispredict, exp_ip, i % 2); end
    end
    n_cmp++; if (empty !== 1'b1 || inst_cnt !== 4'd11 || mispred_cnt !== 4'd4) begin n_bad++; $display("FAIL full_drain got empty %b cnt %0d/%0d want 1 11/4", empty, inst_cnt, mispred_cnt); end
  endtask

  task automatic test_simul;
    do_reset;
    for (int i = 0; i < 8; i++) cyc(1, 64'h400 + 64'(4 * i), 0, 0, 0, 0, 0);
    n_cmp++; if (pred_ready !== 1'b0) begin n_bad++; $display("FAIL simul_ready got %b want 0", pred_ready); end
    cyc(1, 64'hBAD, 0, 1, 1, 0, 0);
    n_cmp++; if (occupancy !== 4'd7 || upd_ip !== 64'h400 || upd_valid !== 1'b1) begin n_bad++; $display("FAIL simul_full got occ %0d ip %h uv %b want 7 400 1", occupancy, upd_ip, upd_valid); end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (occupancy !== 4'd3 || upd_ip !== 64'h410) begin n_bad++; $display("FAIL simul_drain got occ %0d ip %h want 3 410", occupancy, upd_ip); end
    cyc(1, 64'h500, 0, 1, 0, 0, 0);
    n_cmp++; if (occupancy !== 4'd3 || upd_ip !== 64'h414) begin n_bad++; $display("FAIL simul_mid got occ %0d ip %h want 3 414", occupancy, upd_ip); end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (upd_ip !== 64'h500 || empty !== 1'b1) begin n_bad++; $display("FAIL simul_tail got ip %h empty %b want 500 1", upd_ip, empty); end
  endtask

  task automatic test_underflow;
    do_reset;
    cyc(0, 0, 0, 1, 1, 0, 0);
    n_cmp++; if (upd_valid !== 1'b0 || inst_cnt !== 4'd0 || underflow_err !== 1'b1) begin n_bad++; $display("FAIL uflow_set got uv %b cnt %0d err %b want 0 0 1", upd_valid, inst_cnt, underflow_err); end
    cyc(1, 64'h600, 1, 1, 1, 0, 0);
    n_cmp++; if (occupancy !== 4'd1 || upd_valid !== 1'b0) begin n_bad++; $display("FAIL uflow_push got occ %0d uv %b want 1 0", occupancy, upd_valid); end
    cyc(0, 0, 0, 1, 1, 0, 0);
    n_cmp++; if (underflow_err !== 1'b1 || upd_ip !== 64'h600 || inst_cnt !== 4'd1) begin n_bad++; $display("FAIL uflow_sticky got err %b ip %h cnt %0d want 1 600 1", underflow_err, upd_ip, inst_cnt); end
  endtask

  task automatic test_flush;
    do_reset;
    for (int i = 0; i < 7; i++) cyc(1, 64'h700 + 64'(4 * i), 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (occupancy !== 4'd5 || inst_cnt !== 4'd2 || mispred_cnt !== 4'd2) begin n_bad++; $display("FAIL flush_pre got occ %0d cnt %0d/%0d want 5 2/2", occupancy, inst_cnt, mispred_cnt); end
    cyc(1, 64'hBAD, 1, 1, 0, 1, 0);
    n_cmp++; if (occupancy !== 4'd0 || empty !== 1'b1 || upd_valid !== 1'b0) begin n_bad++; $display("FAIL flush_clr got occ %0d empty %b uv %b want 0 1 0", occupancy, empty, upd_valid); end
    n_cmp++; if (inst_cnt !== 4'd2 || mispred_cnt !== 4'd2 || underflow_err !== 1'b0) begin n_bad++; $display("FAIL flush_cnt got %0d/%0d err %b want 2/2 0", inst_cnt, mispred_cnt, underflow_err); end
    cyc(1, 64'h800, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 1);
    n_cmp++; if (inst_cnt !== 4'd1 || mispred_cnt !== 4'd1 || upd_ip !== 64'h800) begin n_bad++; $display("FAIL flush_clrpop got %0d/%0d ip %h want 1/1 800", inst_cnt, mispred_cnt, upd_ip); end
  endtask

  task automatic test_saturate;
    do_reset;
    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 64'h900, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (inst_cnt !== 4'd15 || mispred_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_15 got %0d/%0d want 15/15", inst_cnt, mispred_cnt); end
    cyc(1, 64'h904, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (inst_cnt !== 4'd15 || mispred_cnt !== 4'd15 || upd_valid !== 1'b1) begin n_bad++; $display("FAIL sat_hold got %0d/%0d uv %b want 15/15 1", inst_cnt, mispred_cnt, upd_valid); end
    for (int i = 0; i < 3; i++) cyc(1, 64'hA00, 0, 0, 0, 0, 0);
    pred_valid = 1; pred_ip = 64'hA04; res_valid = 1;
    @(posedge clk); #2;
    reset = 1; #1;
    n_cmp++; if (occupancy !== 4'd0 || {empty, full, pred_ready} !== 3'b101 || upd_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst got occ %0d flags %b uv %b want 0 101 0", occupancy, {empty, full, pred_ready}, upd_valid); end
    n_cmp++; if (inst_cnt !== 4'd0 || mispred_cnt !== 4'd0 || underflow_err !== 1'b0 || upd_ip !== 64'h0) begin n_bad++; $display("FAIL async_cnt got %0d/%0d err %b ip %h want 0/0 0 0", inst_cnt, mispred_cnt, underflow_err, upd_ip); end
    @(posedge clk); #1;
    n_cmp++; if (upd_valid !== 1'b0 || occupancy !== 4'd0) begin n_bad++; $display("FAIL async_hold got uv %b occ %0d want 0 0", upd_valid, occupancy); end
    pred_valid = 0; res_valid = 0; reset = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full;
    test_simul;
    test_underflow;
    test_flush;
    test_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
